// File: rtl/free_list_mp.sv
// Multi-port physical-register free list for the rename stage.
// A free mask (1 = free) grants the lowest free tags to requesting lanes in
// lane order, absorbs commit releases, and keeps snapshots for mispredict
// recovery. The free count is a popcount of the registered mask.
module free_list_mp #(
  parameter int PHYS_REGS   = 64,
  parameter int ARCH_REGS   = 32,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2,
  parameter int NUM_CKPT    = 4,
  parameter int PW          = $clog2(PHYS_REGS),
  parameter int CW          = $clog2(PHYS_REGS + 1),
  parameter int IW          = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ALLOC_PORTS-1:0]      alloc_req,
  output logic                        alloc_ok,
  output logic [ALLOC_PORTS*PW-1:0]   alloc_phys,
  input  logic [FREE_PORTS-1:0]       free_en,
  input  logic [FREE_PORTS*PW-1:0]    free_phys,
  input  logic                        ckpt_save,
  input  logic                        ckpt_restore,
  input  logic [IW-1:0]               ckpt_id,
  output logic [CW-1:0]               free_count,
  output logic                        err_double_free
);

  // Architectural registers start mapped (allocated); the rest start free.
  localparam logic [PHYS_REGS-1:0] RST_MASK =
    {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  logic [PHYS_REGS-1:0] mask_q, mask_d;
  logic [PHYS_REGS-1:0] ckpt_q [NUM_CKPT];
  logic                 err_q, err_d;

  logic [PHYS_REGS-1:0] avail;
  logic [PHYS_REGS-1:0] pick_mask;
  logic [PHYS_REGS-1:0] granted;
  logic [PHYS_REGS-1:0] freed;
  logic [PW-1:0]        lane_tag [ALLOC_PORTS];
  logic [PW-1:0]        rel_tag;
  logic                 found;
  logic                 dbl_free;
  logic [31:0]          req_cnt;
  logic [CW-1:0]        pop_cnt;
  logic [PHYS_REGS-1:0] post_alloc;

  // Free count is always derived from the mask so it can never drift.
  always_comb begin
    pop_cnt = '0;
    for (int b = 0; b < PHYS_REGS; b++) begin
      pop_cnt = pop_cnt + CW'(mask_q[b]);
    end
  end

  assign free_count = pop_cnt;

  // Count requesting lanes; the group is granted only if all of them fit.
  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      req_cnt = req_cnt + 32'(alloc_req[i]);
    end
  end

  assign alloc_ok = (req_cnt <= 32'(pop_cnt)) && !ckpt_restore;

  // Walk lanes in order; each requesting lane takes the lowest tag still
  // unclaimed by earlier lanes.
  always_comb begin
    avail     = mask_q;
    pick_mask = '0;
    found     = 1'b0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      lane_tag[i] = '0;
      found       = 1'b0;
      if (alloc_req[i]) begin
        for (int b = 0; b < PHYS_REGS; b++) begin
          if (!found && avail[b]) begin
            lane_tag[i]  = PW'(b);
            avail[b]     = 1'b0;
            pick_mask[b] = 1'b1;
            found        = 1'b1;
          end
        end
      end
    end
  end

  // Grants are all-or-nothing: a stalled group drives zero on every lane.
  always_comb begin
    alloc_phys = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      if (alloc_ok && alloc_req[i]) begin
        alloc_phys[i*PW +: PW] = lane_tag[i];
      end
    end
  end

  assign granted = alloc_ok ? pick_mask : '0;

  // Collect releases and flag any that hit an already-free tag, including
  // two lanes releasing the same tag in one cycle.
  always_comb begin
    freed    = '0;
    dbl_free = 1'b0;
    rel_tag  = '0;
    for (int j = 0; j < FREE_PORTS; j++) begin
      rel_tag = free_phys[j*PW +: PW];
      if (free_en[j]) begin
        if (mask_q[rel_tag] || freed[rel_tag]) begin
          dbl_free = 1'b1;
        end
        freed[rel_tag] = 1'b1;
      end
    end
  end

  assign post_alloc = (mask_q & ~granted) | freed;

  // Restore replaces the mask with the snapshot, still honouring this
  // cycle's commits; otherwise the mask takes allocations and releases.
  always_comb begin
    mask_d = post_alloc;
    if (ckpt_restore) begin
      mask_d = ckpt_q[ckpt_id] | freed;
    end
    err_d = err_q | dbl_free;
  end

  // Mask and sticky error register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= RST_MASK;
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end

  // Snapshots: committed frees land in every slot so they survive recovery;
  // a save is dropped when a restore happens in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        ckpt_q[s] <= RST_MASK;
      end
    end else begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        if (ckpt_save && !ckpt_restore && (ckpt_id == IW'(s))) begin
          ckpt_q[s] <= post_alloc;
        end else begin
          ckpt_q[s] <= ckpt_q[s] | freed;
        end
      end
    end
  end

  assign err_double_free = err_q;

endmodule

// File: tb/tb_free_list_mp.sv
// Directed bench for free_list_mp with the default parameters.
module tb_free_list_mp;

  localparam int PW = 6;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    alloc_req;
  logic          alloc_ok;
  logic [11:0]   alloc_phys;
  logic [1:0]    free_en;
  logic [11:0]   free_phys;
  logic          ckpt_save;
  logic          ckpt_restore;
  logic [1:0]    ckpt_id;
  logic [CW-1:0] free_count;
  logic          err_double_free;

  int n_checks = 0;
  int n_pass   = 0;

  free_list_mp dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .alloc_req       (alloc_req),
    .alloc_ok        (alloc_ok),
    .alloc_phys      (alloc_phys),
    .free_en         (free_en),
    .free_phys       (free_phys),
    .ckpt_save       (ckpt_save),
    .ckpt_restore    (ckpt_restore),
    .ckpt_id         (ckpt_id),
    .free_count      (free_count),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Apply one cycle of inputs on the falling edge and settle.
  task automatic drive(input logic [1:0] req, input logic [1:0] fen,
                       input logic [5:0] f0, input logic [5:0] f1,
                       input logic sv, input logic rs, input logic [1:0] id);
    @(negedge clk);
    alloc_req    = req;
    free_en      = fen;
    free_phys    = {f1, f0};
    ckpt_save    = sv;
    ckpt_restore = rs;
    ckpt_id      = id;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    alloc_req = '0; free_en = '0; free_phys = '0;
    ckpt_save = 1'b0; ckpt_restore = 1'b0; ckpt_id = '0;
    #23;
    check("rst_count", 32'(free_count), 32);
    check("rst_err", 32'(err_double_free), 0);
    reset_n = 1'b1;

    // Two-lane grant
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("g1_ok", 32'(alloc_ok), 1);
    check("g1_l0", 32'(alloc_phys[5:0]), 32);
    check("g1_l1", 32'(alloc_phys[11:6]), 33);
    tick();
    check("g1_count", 32'(free_count), 30);

    // Release of 32 not forwarded to same-cycle grant
    drive(2'b01, 2'b01, 6'd32, 6'd0, 1'b0, 1'b0, 2'd0);
    check("nofwd_l0", 32'(alloc_phys[5:0]), 34);
    tick();
    check("nofwd_count", 32'(free_count), 30);
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("recycle_l0", 32'(alloc_phys[5:0]), 32);
    tick();
    check("recycle_count", 32'(free_count), 29);

    // Lane 1 alone
    drive(2'b10, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("l1only_l0", 32'(alloc_phys[5:0]), 0);
    check("l1only_l1", 32'(alloc_phys[11:6]), 35);
    tick();
    check("l1only_count", 32'(free_count), 28);

    // Free 32 and 34 -> only 33,35 allocated, then save slot 1 (only 33,35 held)
    drive(2'b00, 2'b11, 6'd32, 6'd34, 1'b0, 1'b0, 2'd0);
    tick();
    check("rel2_count", 32'(free_count), 30);
    drive(2'b00, 2'b01, 6'd35, 6'd0, 1'b1, 1'b0, 2'd1);
    tick();
    check("save_count", 32'(free_count), 31);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("post_save_l0", 32'(alloc_phys[5:0]), 32);
    check("post_save_l1", 32'(alloc_phys[11:6]), 34);
    tick();
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("post_save_l0b", 32'(alloc_phys[5:0]), 35);
    tick();
    check("pre_free33_count", 32'(free_count), 28);
    drive(2'b00, 2'b01, 6'd33, 6'd0, 1'b0, 1'b0, 2'd0);
    tick();
    check("free33_count", 32'(free_count), 29);

    // Restore slot 1: snapshot held 33 only, and 33 was committed since
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 2'd1);
    check("restore_ok", 32'(alloc_ok), 0);
    check("restore_phys", 32'(alloc_phys), 0);
    tick();
    check("restore_count", 32'(free_count), 32);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("after_rst_l0", 32'(alloc_phys[5:0]), 32);
    check("after_rst_l1", 32'(alloc_phys[11:6]), 33);
    tick();
    check("after_rst_count", 32'(free_count), 30);

    // Save and restore together: restore wins, slot 2 keeps the reset image
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b1, 1'b1, 2'd2);
    tick();
    check("sr_count", 32'(free_count), 32);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    tick();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1, 2'd2);
    tick();
    check("sr_slot2_count", 32'(free_count), 32);

    // Drain to one free register
    for (int k = 0; k < 15; k++) begin
      drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
      check("drain_pair", 32'(alloc_phys), 32'({6'(33 + 2*k), 6'(32 + 2*k)}));
      tick();
    end
    check("drain_count", 32'(free_count), 2);
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("drain_62", 32'(alloc_phys[5:0]), 62);
    tick();
    check("one_left", 32'(free_count), 1);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("stall_ok", 32'(alloc_ok), 0);
    check("stall_phys", 32'(alloc_phys), 0);
    tick();
    check("stall_count", 32'(free_count), 1);
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("n0_ok", 32'(alloc_ok), 1);
    drive(2'b10, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("exact_ok", 32'(alloc_ok), 1);
    check("exact_l1", 32'(alloc_phys[11:6]), 63);
    tick();
    check("empty_count", 32'(free_count), 0);
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("empty_ok", 32'(alloc_ok), 0);
    tick();

    // Double free of 40
    drive(2'b00, 2'b01, 6'd40, 6'd0, 1'b0, 1'b0, 2'd0);
    tick();
    check("free40_err", 32'(err_double_free), 0);
    check("free40_count", 32'(free_count), 1);
    drive(2'b00, 2'b01, 6'd40, 6'd0, 1'b0, 1'b0, 2'd0);
    tick();
    check("dbl_err", 32'(err_double_free), 1);
    check("dbl_count", 32'(free_count), 1);
    idle();
    tick();
    check("dbl_sticky", 32'(err_double_free), 1);

    // Asynchronous reset mid-burst
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count", 32'(free_count), 32);
    check("arst_err", 32'(err_double_free), 0);
    check("arst_l0", 32'(alloc_phys[5:0]), 32);
    idle();
    reset_n = 1'b1;
    tick();
    check("arst_release_count", 32'(free_count), 32);

    // Same tag on both release lanes (tag 5 starts allocated)
    drive(2'b00, 2'b11, 6'd5, 6'd5, 1'b0, 1'b0, 2'd0);
    tick();
    check("dup_err", 32'(err_double_free), 1);
    check("dup_count", 32'(free_count), 33);
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0, 2'd0);
    check("arch_recycle", 32'(alloc_phys[5:0]), 5);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/free_list_mp.md
Name: free_list_mp

Overview:
- Multi-port physical-register free list for the rename stage.
- Grants up to ALLOC_PORTS physical registers and accepts up to FREE_PORTS releases from commit each cycle.
- Keeps NUM_CKPT snapshots of the free mask so rename can recover on a branch mispredict.
- Reports an exact free count so rename can stall a whole group instead of splitting it.

Parameters:
PHYS_REGS, 64, number of physical registers; power of two, at least 2*ARCH_REGS.
ARCH_REGS, 32, registers 0..ARCH_REGS-1 hold the initial architectural mapping and are allocated at reset.
ALLOC_PORTS, 2, allocation lanes per cycle.
FREE_PORTS, 2, release lanes per cycle.
NUM_CKPT, 4, number of checkpoint slots.
PW, $clog2(PHYS_REGS), physical tag width (derived).
CW, $clog2(PHYS_REGS+1), free-count width (derived).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
alloc_req  in  ALLOC_PORTS  per-lane allocation request.
alloc_ok  out  1  all requested lanes granted this cycle (combinational).
alloc_phys  out  ALLOC_PORTS*PW  granted tag per lane; lane i in bits [i*PW +: PW] (combinational).
free_en  in  FREE_PORTS  per-lane release valid.
free_phys  in  FREE_PORTS*PW  released tags, packed like alloc_phys.
ckpt_save  in  1  snapshot the post-allocation mask into slot ckpt_id.
ckpt_restore  in  1  restore the mask from slot ckpt_id.
ckpt_id  in  $clog2(NUM_CKPT)  checkpoint slot index.
free_count  out  CW  number of free registers in the current mask (registered state, combinational popcount).
err_double_free  out  1  sticky: a release hit an already-free register.

Behaviour:
- Free mask: 1 = free. On reset_n low, asynchronously:
  - mask bits 0..ARCH_REGS-1 = 0, all others = 1; every checkpoint slot = the same value.
  - err_double_free = 0.
  - free_count reads PHYS_REGS-ARCH_REGS from the first cycle after reset.
- Allocation (combinational from the current mask):
  - Let n = popcount(alloc_req).
  - alloc_ok = (n <= free_count) and not ckpt_restore.
  - Lanes are served in ascending lane order: the k-th requesting lane gets the k-th lowest free index.
  - Non-requesting lanes, and every lane when alloc_ok=0, drive alloc_phys = 0.
  - All-or-nothing: when alloc_ok=0 no bit is cleared and the group must stall. Partial grants are forbidden.
  - n = 0 gives alloc_ok = 1 with no effect.
- Release:
  - Each enabled free lane sets its mask bit at the next edge.
  - Releases are not forwarded to same-cycle allocation.
  - Every release also sets the same bit in every checkpoint slot, because committed frees survive recovery.
  - Releasing a bit that is already 1 still leaves it at 1 and sets err_double_free.
  - Two lanes releasing the same tag in one cycle also set err_double_free.
  - Tags below ARCH_REGS may be released; a register freed at commit is legal to recycle.
- Next mask:
  - Normal cycle: (mask & ~granted) | freed.
  - ckpt_save: the slot receives (mask & ~granted) | freed, the same value as the next mask.
  - ckpt_restore: next mask = slot[ckpt_id] | freed. Allocation is suppressed that cycle (alloc_ok=0).
  - save and restore in the same cycle: restore wins and save is ignored.
- free_count: popcount of the registered mask, never a running counter. Must equal PHYS_REGS - (allocated count) at all times.
- Reset mid-operation: state returns to reset values immediately. Outstanding grants are lost; upstream rename resets with the block.
- No internal FSM beyond mask and checkpoint registers. Single-cycle grant latency; release visible one cycle after free_en.

Test Plan:
- Reset with defaults -> free_count=32; alloc_req=2'b11 -> alloc_ok=1, alloc_phys lane0=32, lane1=33; next cycle free_count=30.
- alloc_req=2'b10 only -> lane1 gets 32, lane0 drives 0; then allocate until free_count=1 and request 2'b11 -> alloc_ok=0, count stays 1, no bit cleared.
- Allocate 32,33; next cycle free 32 while requesting 2'b01 -> grant is 34, not 32 (no forwarding); following cycle an allocation returns 32.
- Save to slot 1, allocate 34,35, free 33, then restore slot 1 -> mask has 34,35 free again and 33 free; alloc_ok=0 during the restore cycle.
- Free tag 40 while it is already free -> err_double_free=1 and stays high until reset; free_count unchanged.
- Assert reset_n low mid-burst with alloc_req active -> outputs and mask return to reset values asynchronously, free_count=32 after release.
